// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

    // Register map selected by reg_sel on the bus.
    typedef enum logic [1:0] {
        STATUS = 2'd0,
        MASK   = 2'd1,
        VECTOR = 2'd2,
        EOI    = 2'd3
    } intc_reg_e;

    // Request/service handshake states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    // Width of a source index; a single source still needs one bit.
    function automatic int vec_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // Bit position of the in-service flag in a VECTOR read.
    function automatic int in_service_bit(input int word_size);
        return word_size - 1;
    endfunction

endpackage

// File: rtl/intc_if.sv
// CPU-side register bus and irq/vector handshake of the interrupt controller.
interface intc_if
    import intc_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_SRC   = 8
);
    localparam int VEC_W = vec_width(NUM_SRC);

    logic [WORD_SIZE-1:0] data;
    intc_reg_e            reg_sel;
    logic                 rd;
    logic                 wr;
    logic                 irq;
    logic                 irq_ack;
    logic [VEC_W-1:0]     vector;

    modport master (
        output data, reg_sel, rd, wr, irq_ack,
        input  irq, vector
    );

    modport slave (
        input  data, reg_sel, rd, wr, irq_ack,
        output irq, vector
    );

endinterface

// File: rtl/intc_arbiter.sv
// Combinational search for the first eligible source starting at a given
// index and wrapping around. Fixed priority is simply start = 0.
module intc_arbiter
    import intc_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    localparam int VEC_W   = vec_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [VEC_W-1:0]   start,
    output logic [VEC_W-1:0]   winner,
    output logic               valid
);

    int               idx;
    logic [VEC_W-1:0] idx_v;

    // Walk the sources in rotated order and keep the first eligible one.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx   = (int'(start) + i) % NUM_SRC;
            idx_v = VEC_W'(idx);
            if (!valid && eligible[idx_v]) begin
                valid  = 1'b1;
                winner = idx_v;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/intc.sv
// Interrupt controller: edge-captures sources into pending, masks them,
// arbitrates one winner and runs the irq / irq_ack / EOI handshake.
// Optional macro INTC_ROUND_ROBIN_EN switches arbitration from fixed
// lowest-index priority to round-robin starting after the last grant.
module intc
    import intc_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_SRC   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   src,
    intc_if.slave                bus,
    output tri   [WORD_SIZE-1:0] out
);

    localparam int VEC_W  = vec_width(NUM_SRC);
    localparam int IS_BIT = in_service_bit(WORD_SIZE);

    logic [NUM_SRC-1:0]   src_q_r;
    logic [NUM_SRC-1:0]   pending_r;
    logic [NUM_SRC-1:0]   mask_r;
    intc_state_e          state_r;
    logic                 irq_r;
    logic [VEC_W-1:0]     vector_r;
    logic                 in_service_r;

    logic [NUM_SRC-1:0]   edge_s;
    logic [NUM_SRC-1:0]   eligible_s;
    logic [NUM_SRC-1:0]   w1c_s;
    logic [NUM_SRC-1:0]   ack_clr_s;
    logic [NUM_SRC-1:0]   pending_nxt_s;
    logic                 wr_status_s;
    logic                 wr_mask_s;
    logic                 wr_eoi_s;
    logic                 ack_s;
    logic [VEC_W-1:0]     start_s;
    logic [VEC_W-1:0]     winner_s;
    logic                 win_valid_s;
    logic [WORD_SIZE-1:0] rdata_s;
    logic                 unused_data_s;

    assign edge_s      = src & ~src_q_r;
    assign eligible_s  = pending_r & mask_r;
    assign wr_status_s = bus.wr && (bus.reg_sel == STATUS);
    assign wr_mask_s   = bus.wr && (bus.reg_sel == MASK);
    assign wr_eoi_s    = bus.wr && (bus.reg_sel == EOI);
    assign ack_s       = (state_r == REQ) && bus.irq_ack;
    assign w1c_s       = wr_status_s ? bus.data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    // A new edge wins over any clear landing in the same cycle.
    assign pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | edge_s;
    // Data bits above the source count are intentionally ignored.
    assign unused_data_s = &{1'b0, bus.data};

    // One-hot clear of the granted source when the CPU accepts it.
    always_comb begin
        ack_clr_s = '0;
        if (ack_s) begin
            ack_clr_s[vector_r] = 1'b1;
        end else begin
            ack_clr_s = '0;
        end
    end

`ifdef INTC_ROUND_ROBIN_EN
    logic [VEC_W-1:0] last_grant_r;

    // Remember the most recently accepted source for round-robin rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= VEC_W'(NUM_SRC - 1);
        end else if (ack_s) begin
            last_grant_r <= vector_r;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign start_s = (last_grant_r == VEC_W'(NUM_SRC - 1)) ? {VEC_W{1'b0}}
                                                           : last_grant_r + VEC_W'(1);
`else
    assign start_s = {VEC_W{1'b0}};
`endif

    intc_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arbiter (
        .eligible (eligible_s),
        .start    (start_s),
        .winner   (winner_s),
        .valid    (win_valid_s)
    );

    // Source history and pending latch; a source high at reset release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q_r   <= '0;
            pending_r <= '0;
        end else begin
            src_q_r   <= src;
            pending_r <= pending_nxt_s;
        end
    end

    // Software-controlled enable mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= '0;
        end else if (wr_mask_s) begin
            mask_r <= bus.data[NUM_SRC-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Handshake FSM; vector is frozen from the grant until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            irq_r        <= 1'b0;
            vector_r     <= '0;
            in_service_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        vector_r <= winner_s;
                        irq_r    <= 1'b1;
                        state_r  <= REQ;
                    end else begin
                        irq_r    <= 1'b0;
                    end
                end
                REQ: begin
                    // Masking or clearing the requested bit does not withdraw it.
                    if (ack_s) begin
                        irq_r        <= 1'b0;
                        in_service_r <= 1'b1;
                        state_r      <= SERVICE;
                    end else begin
                        irq_r        <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (wr_eoi_s) begin
                        in_service_r <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        in_service_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    irq_r        <= 1'b0;
                    in_service_r <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read mux.
    always_comb begin
        rdata_s = '0;
        case (bus.reg_sel)
            STATUS: rdata_s[NUM_SRC-1:0] = pending_r;
            MASK:   rdata_s[NUM_SRC-1:0] = mask_r;
            VECTOR: begin
                rdata_s[VEC_W-1:0] = vector_r;
                rdata_s[IS_BIT]    = in_service_r;
            end
            EOI:     rdata_s = '0;
            default: rdata_s = '0;
        endcase
    end

    assign out        = bus.rd ? rdata_s : {WORD_SIZE{1'bz}};
    assign bus.irq    = irq_r;
    assign bus.vector = vector_r;

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for the interrupt controller.
module tb_intc;
    import intc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src;
    tri   [31:0] out;
    logic [31:0] v;
    logic [2:0]  exp_grant [4];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    intc_if #(.WORD_SIZE(32), .NUM_SRC(8)) bus ();

    intc #(.WORD_SIZE(32), .NUM_SRC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (src),
        .bus   (bus),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input intc_reg_e r, output logic [31:0] val);
        bus.reg_sel = r;
        bus.rd      = 1'b1;
        #1;
        val         = out;
        bus.rd      = 1'b0;
    endtask

    task automatic wr_reg(input intc_reg_e r, input logic [31:0] d);
        bus.reg_sel = r;
        bus.data    = d;
        bus.wr      = 1'b1;
        tick();
        bus.wr      = 1'b0;
        bus.data    = 32'd0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    initial begin
`ifdef INTC_ROUND_ROBIN_EN
        exp_grant[0] = 3'd0; exp_grant[1] = 3'd1; exp_grant[2] = 3'd0; exp_grant[3] = 3'd1;
`else
        exp_grant[0] = 3'd0; exp_grant[1] = 3'd0; exp_grant[2] = 3'd0; exp_grant[3] = 3'd0;
`endif
        rst_n = 1'b0; src = 8'h00;
        bus.data = 32'd0; bus.reg_sel = STATUS; bus.rd = 1'b0; bus.wr = 1'b0; bus.irq_ack = 1'b0;
        #2;
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_vector", {29'd0, bus.vector}, 32'd0);
        rd_reg(STATUS, v); chk("rst_status", v, 32'h0000_0000);
        rd_reg(MASK, v);   chk("rst_mask", v, 32'h0000_0000);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();

        // Single source, 2-cycle latency, ack and EOI
        wr_reg(MASK, 32'hFFFF_FF01);
        rd_reg(MASK, v); chk("mask_upper_ignored", v, 32'h0000_0001);
        src = 8'h01; tick(); src = 8'h00;
        chk("t1_irq_after_pend", {31'd0, bus.irq}, 32'd0);
        rd_reg(STATUS, v); chk("t1_status_pend", v, 32'h0000_0001);
        tick();
        chk("t1_irq_high", {31'd0, bus.irq}, 32'd1);
        chk("t1_vector", {29'd0, bus.vector}, 32'd0);
        ack();
        chk("t1_irq_low_after_ack", {31'd0, bus.irq}, 32'd0);
        rd_reg(STATUS, v); chk("t1_status_cleared", v, 32'h0000_0000);
        rd_reg(VECTOR, v); chk("t1_vector_reg", v, 32'h8000_0000);
        rd_reg(EOI, v);    chk("t1_eoi_read", v, 32'h0000_0000);
        wr_reg(EOI, 32'd0);
        tick();
        chk("t1_idle_irq", {31'd0, bus.irq}, 32'd0);
        rd_reg(VECTOR, v); chk("t1_vector_reg_idle", v, 32'h0000_0000);

        // Two simultaneous sources, lowest index first
        wr_reg(MASK, 32'h0000_00FF);
        src = 8'h0A; tick(); src = 8'h00; tick();
        chk("t2_irq_first", {31'd0, bus.irq}, 32'd1);
        chk("t2_vector_first", {29'd0, bus.vector}, 32'd1);
        ack();
        chk("t2_irq_low", {31'd0, bus.irq}, 32'd0);
        rd_reg(STATUS, v); chk("t2_status_after_ack", v, 32'h0000_0008);
        wr_reg(EOI, 32'hDEAD_BEEF);
        chk("t2_irq_at_eoi", {31'd0, bus.irq}, 32'd0);
        tick();
        chk("t2_irq_second", {31'd0, bus.irq}, 32'd1);
        chk("t2_vector_second", {29'd0, bus.vector}, 32'd3);
        wr_reg(EOI, 32'd0);
        chk("t2_eoi_in_req_ignored", {31'd0, bus.irq}, 32'd1);
        ack();
        wr_reg(EOI, 32'd0);

        // Masked pending, then unmask; W1C before unmask
        wr_reg(MASK, 32'h0000_0000);
        src = 8'h04; tick(); src = 8'h00; tick(); tick();
        chk("t3_masked_no_irq", {31'd0, bus.irq}, 32'd0);
        rd_reg(STATUS, v); chk("t3_status_masked", v, 32'h0000_0004);
        wr_reg(MASK, 32'h0000_0004);
        chk("t3_irq_not_yet", {31'd0, bus.irq}, 32'd0);
        tick();
        chk("t3_irq_unmasked", {31'd0, bus.irq}, 32'd1);
        chk("t3_vector", {29'd0, bus.vector}, 32'd2);
        wr_reg(MASK, 32'h0000_0000);
        chk("t3_mask_in_req_keeps", {31'd0, bus.irq}, 32'd1);
        ack();
        wr_reg(EOI, 32'd0);
        src = 8'h04; tick(); src = 8'h00; tick();
        rd_reg(STATUS, v); chk("t3_status_repend", v, 32'h0000_0004);
        wr_reg(STATUS, 32'h0000_0004);
        rd_reg(STATUS, v); chk("t3_status_w1c", v, 32'h0000_0000);
        wr_reg(MASK, 32'h0000_0004);
        tick(); tick();
        chk("t3_no_irq_after_w1c", {31'd0, bus.irq}, 32'd0);

        // Set wins over W1C in the same cycle
        src = 8'h01; tick(); src = 8'h00; tick();
        rd_reg(STATUS, v); chk("t4_status_pre", v, 32'h0000_0001);
        src = 8'h01; wr_reg(STATUS, 32'h0000_0001); src = 8'h00;
        rd_reg(STATUS, v); chk("t4_set_wins", v, 32'h0000_0001);
        wr_reg(STATUS, 32'h0000_0001);
        rd_reg(STATUS, v); chk("t4_w1c_alone", v, 32'h0000_0000);

        // Asynchronous reset in the middle of a request
        wr_reg(MASK, 32'h0000_0010);
        src = 8'h10; tick(); src = 8'h00; tick();
        chk("t5_irq_req", {31'd0, bus.irq}, 32'd1);
        chk("t5_vector_req", {29'd0, bus.vector}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t5_irq_async", {31'd0, bus.irq}, 32'd0);
        chk("t5_vector_async", {29'd0, bus.vector}, 32'd0);
        rd_reg(STATUS, v); chk("t5_status_async", v, 32'h0000_0000);
        rd_reg(MASK, v);   chk("t5_mask_async", v, 32'h0000_0000);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        chk("t5_irq_after_release", {31'd0, bus.irq}, 32'd0);

        // Repeated re-pending of sources 0 and 1
        wr_reg(MASK, 32'h0000_0003);
        src = 8'h03; tick(); src = 8'h00; tick();
        chk("t6_irq_0", {31'd0, bus.irq}, 32'd1);
        chk("t6_grant_0", {29'd0, bus.vector}, {29'd0, exp_grant[0]});
        ack();
        for (int k = 1; k < 4; k++) begin
            src = 8'h03; tick(); src = 8'h00;
            wr_reg(EOI, 32'd0);
            tick();
            chk($sformatf("t6_irq_%0d", k), {31'd0, bus.irq}, 32'd1);
            chk($sformatf("t6_grant_%0d", k), {29'd0, bus.vector}, {29'd0, exp_grant[k]});
            ack();
        end
        wr_reg(EOI, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/intc.md
Name: intc

Overview:
- Interrupt controller that collects up to NUM_SRC interrupt sources (timer timeout and other peripherals), latches them as pending and masks them.
- Arbitrates one winner and presents a single irq/vector handshake to the CPU.
- Holds the winner in-service until software writes end-of-interrupt.
- Sits on the same memory-mapped register bus as the timer: data, reg_sel, rd, wr, tri-state out.

Parameters:
- WORD_SIZE, 32, bus data width.
- NUM_SRC, 8, number of interrupt sources; must satisfy 1 <= NUM_SRC <= WORD_SIZE.
- VEC_W, $clog2(NUM_SRC) (minimum 1), vector width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- src  input  NUM_SRC  interrupt sources, synchronous to clk; e.g. timer timeout on src[0].
- data  input  WORD_SIZE  write data.
- reg_sel  input  intc_reg_e  register select.
- out  output tri  WORD_SIZE  read data; 'hz when rd=0.
- rd  input  1  read strobe.
- wr  input  1  write strobe.
- irq  output  1  interrupt request to CPU.
- irq_ack  input  1  CPU accepts the current request.
- vector  output  VEC_W  index of the requested / in-service source.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pending=0, mask=0, src_q=0, state=IDLE, irq=0, vector=0.
  - last_grant=NUM_SRC-1 (round-robin only).
  - Reset mid-handshake aborts with no residue.
- Edge capture:
  - src_q <= src each cycle.
  - A rising edge (src & ~src_q) sets pending[i] at the next clk edge.
  - A source already high when reset is released counts as an edge.
  - A held-high source does not re-pend until it falls and rises again.
- Registers (reads combinational, out = rd ? value : 'hz):
  - STATUS: read returns pending, zero-extended. Write is write-1-to-clear on pending.
  - MASK: read/write; bit i=1 enables source i. Bits >= NUM_SRC read 0 and are ignored on write.
  - VECTOR: read returns {in_service, vector} with in_service at bit WORD_SIZE-1. Writes ignored.
  - EOI: write ends service; any data. Read returns 0.
- Set/clear priority: if the same cycle sets and clears pending[i] (edge vs STATUS W1C or grant clear), set wins.
- Arbitration: eligible = pending & mask. Winner is the lowest eligible index (fixed priority).
- FSM intc_state_e:
  - IDLE: if eligible != 0, latch vector=winner, go REQ; irq=1 from the next cycle.
  - REQ: irq=1, vector stable.
    - irq_ack=1: clear pending[vector], go SERVICE, irq=0 next cycle.
    - A mask write or STATUS clear of the requested bit during REQ does not withdraw the request.
  - SERVICE: irq=0, in_service=1.
    - EOI write: go IDLE. Earliest new irq is 2 cycles after the EOI write edge.
  - EOI in IDLE or REQ: ignored. irq_ack outside REQ: ignored.
- Latency: source edge to irq high = 2 clk (pend, then IDLE->REQ). irq_ack to irq low = 1 clk.
- No nesting: while SERVICE, new edges accumulate in pending only.

Optional Feature:
- Macro: INTC_ROUND_ROBIN_EN.
- Defined:
  - Search starts at (last_grant+1) mod NUM_SRC and wraps; first eligible in that order wins.
  - last_grant <= vector on irq_ack; wraps from NUM_SRC-1 to 0.
- Undefined:
  - Fixed lowest-index priority; no last_grant register exists.

Decomposition:
- intc_pkg:
  - intc_reg_e {STATUS, MASK, VECTOR, EOI}, 2-bit encoding.
  - intc_state_e {IDLE, REQ, SERVICE}.
  - Constant IN_SERVICE_BIT offset helper.
- Sub-module intc_arbiter (combinational), shared by both arbitration modes:
  - Inputs: eligible vector, start index.
  - Outputs: winner index and valid.
  - Fixed priority uses start=0.

Test Plan:
- Reset, MASK=0x01, pulse src[0] at cycle 10 -> irq=1 at cycle 12, vector=0. irq_ack -> irq=0 next cycle, STATUS=0x00, VECTOR read = 0x80000000.
- src[3] and src[1] rise together, MASK=0xFF -> vector=1 first. After ack and EOI, vector=3 two cycles later. STATUS after the first ack reads 0x08.
- MASK=0x00, pulse src[2] -> no irq, STATUS=0x04. Write MASK=0x04 -> irq next-next cycle. Write STATUS=0x04 before MASK instead -> no irq ever.
- STATUS W1C of bit 0 in the same cycle as a src[0] rising edge -> STATUS bit 0 remains 1.
- Assert rst_n=0 during REQ -> irq=0, vector=0, STATUS=0, MASK=0 immediately, without a clk edge.
- INTC_ROUND_ROBIN_EN, src[0] and src[1] repeatedly re-pended, MASK=0x03 -> grants alternate 0,1,0,1. Without the macro -> grants are always 0.
